// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM command/response bundle, used for both requester ports and the controller port.
// The master drives the command; the slave answers with waitrequest and read data.
interface sdram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single SDRAM controller Avalon-MM port.
// Outstanding reads are tagged in an in-order FIFO so returning data is steered to its owner.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAX_PENDING = 8
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    sdram_port_arbiter_if.slave          m0,
    sdram_port_arbiter_if.slave          m1,
    sdram_port_arbiter_if.master         sdr,
    output logic [$clog2(MAX_PENDING):0] pending_count,
    output logic                         err_orphan
);
    localparam int unsigned PtrW = $clog2(MAX_PENDING);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_PENDING);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;

    logic [MAX_PENDING-1:0] tag_q;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        count_q;
    logic                   orphan_q;
    logic [1:0]             rvalid_q;
    logic [DATA_W-1:0]      rdata0_q, rdata1_q;

    logic fifo_full, granted, gnt_sel;
    logic elig0, elig1;
    logic sel_read, sel_write;
    logic issue_rd, issue_wr, accept, push, pop;

    assign fifo_full = (count_q == MaxCnt);
    assign elig0     = m0.write | (m0.read & ~fifo_full);
    assign elig1     = m1.write | (m1.read & ~fifo_full);
    assign granted   = (state_q != StIdle);
    assign gnt_sel   = (state_q == StGrant1);
    assign sel_read  = gnt_sel ? m1.read  : m0.read;
    assign sel_write = gnt_sel ? m1.write : m0.write;

    // Write wins when a requester raises both; a read never goes into a full tag FIFO.
    assign issue_wr = granted & sel_write;
    assign issue_rd = granted & sel_read & ~sel_write & ~fifo_full;
    assign accept   = (issue_rd | issue_wr) & ~sdr.waitrequest;
    assign push     = accept & issue_rd;
    assign pop      = sdr.readdatavalid & (count_q != '0);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        sdr.address    = '0;
        sdr.writedata  = '0;
        sdr.byteenable = '0;
        sdr.read       = issue_rd;
        sdr.write      = issue_wr;
        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (elig0 && elig1) begin
                    state_d = last_grant_q ? StGrant0 : StGrant1;
                end else if (elig0) begin
                    state_d = StGrant0;
                end else if (elig1) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                sdr.address    = gnt_sel ? m1.address    : m0.address;
                sdr.writedata  = gnt_sel ? m1.writedata  : m0.writedata;
                sdr.byteenable = gnt_sel ? m1.byteenable : m0.byteenable;
                if (gnt_sel) begin
                    m1.waitrequest = sdr.waitrequest;
                end else begin
                    m0.waitrequest = sdr.waitrequest;
                end
                // A requester that drops its command while granted forfeits the grant.
                if (!(issue_rd || issue_wr)) begin
                    state_d = StIdle;
                end else if (accept) begin
                    state_d      = StIdle;
                    last_grant_d = gnt_sel;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid_q <= 2'b00;
            if (push) begin
                tag_q[wr_ptr_q] <= gnt_sel;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                if (tag_q[rd_ptr_q]) begin
                    rvalid_q[1] <= 1'b1;
                    rdata1_q    <= sdr.readdata;
                end else begin
                    rvalid_q[0] <= 1'b1;
                    rdata0_q    <= sdr.readdata;
                end
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
            // Data with no owner is dropped and flagged until reset.
            if (sdr.readdatavalid && (count_q == '0)) begin
                orphan_q <= 1'b1;
            end
        end
    end

    assign m0.readdata      = rdata0_q;
    assign m0.readdatavalid = rvalid_q[0];
    assign m1.readdata      = rdata1_q;
    assign m1.readdatavalid = rvalid_q[1];
    assign pending_count    = count_q;
    assign err_orphan       = orphan_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a transaction-level model (owner, tag queue, sticky orphan).
module tb_sdram_port_arbiter;
    localparam int AW   = 25;
    localparam int DW   = 16;
    localparam int MAXP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sdr_bus ();

    logic [AW-1:0] addr[2];
    logic          rd[2];
    logic          wr[2];
    logic [DW-1:0] wdata[2];
    logic [1:0]    be[2];
    logic          s_wait, s_rdv;
    logic [DW-1:0] s_rdata;
    logic [3:0]    pend;
    logic          orph_o;

    assign m0_bus.address    = addr[0];
    assign m0_bus.read       = rd[0];
    assign m0_bus.write      = wr[0];
    assign m0_bus.writedata  = wdata[0];
    assign m0_bus.byteenable = be[0];
    assign m1_bus.address    = addr[1];
    assign m1_bus.read       = rd[1];
    assign m1_bus.write      = wr[1];
    assign m1_bus.writedata  = wdata[1];
    assign m1_bus.byteenable = be[1];
    assign sdr_bus.waitrequest   = s_wait;
    assign sdr_bus.readdata      = s_rdata;
    assign sdr_bus.readdatavalid = s_rdv;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP)) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .sdr          (sdr_bus),
        .pending_count(pend),
        .err_orphan   (orph_o)
    );

    int checks = 0;
    int failures = 0;

    // Model: who holds the grant (-1 none), who won last, tags of reads in flight.
    int            m_owner = -1;
    int            m_last = 1;
    int            tq[$];
    bit            m_orph = 1'b0;
    bit            e_rv[2] = '{1'b0, 1'b0};
    logic [DW-1:0] e_rd[2] = '{16'h0, 16'h0};
    int            ctl_out = 0;

    // Snapshots of DUT outputs from the last step, for literal checks.
    logic          sn_wait[2];
    logic          sn_sr, sn_sw;
    logic [AW-1:0] sn_addr;
    logic [DW-1:0] sn_wd;
    logic          sn_rv[2];
    logic [DW-1:0] sn_rd[2];
    logic [3:0]    sn_pend;
    logic          sn_orph;
    bit            acc[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Called just after inputs change at a negedge; returns at the following negedge.
    task automatic step();
        bit e_sr, e_sw, push_n;
        bit e_wait[2];
        bit el[2];
        int sz, nxt, t;
        #1;
        sz = tq.size();
        e_sr = 1'b0;
        e_sw = 1'b0;
        e_wait[0] = 1'b1;
        e_wait[1] = 1'b1;
        if (m_owner >= 0) begin
            e_sw = wr[m_owner];
            e_sr = rd[m_owner] && !wr[m_owner] && (sz < MAXP);
            e_wait[m_owner] = s_wait;
        end
        chk("sdr_write", sdr_bus.write, e_sw);
        chk("sdr_read", sdr_bus.read, e_sr);
        if (e_sw || e_sr) chk("sdr_address", sdr_bus.address, addr[m_owner]);
        if (e_sw) begin
            chk("sdr_writedata", sdr_bus.writedata, wdata[m_owner]);
            chk("sdr_byteenable", sdr_bus.byteenable, be[m_owner]);
        end
        chk("m0_waitrequest", m0_bus.waitrequest, e_wait[0]);
        chk("m1_waitrequest", m1_bus.waitrequest, e_wait[1]);
        sn_wait[0] = m0_bus.waitrequest;
        sn_wait[1] = m1_bus.waitrequest;
        sn_sr = sdr_bus.read;
        sn_sw = sdr_bus.write;
        sn_addr = sdr_bus.address;
        sn_wd = sdr_bus.writedata;
        acc[0] = (rd[0] || wr[0]) && !m0_bus.waitrequest;
        acc[1] = (rd[1] || wr[1]) && !m1_bus.waitrequest;
        if (sdr_bus.read && !s_wait) ctl_out++;
        if (s_rdv && ctl_out > 0) ctl_out--;
        if (rst) begin
            m_owner = -1;
            m_last = 1;
            tq.delete();
            m_orph = 1'b0;
            e_rv = '{1'b0, 1'b0};
            e_rd = '{16'h0, 16'h0};
            ctl_out = 0;
        end else begin
            el[0] = wr[0] || (rd[0] && sz < MAXP);
            el[1] = wr[1] || (rd[1] && sz < MAXP);
            nxt = m_owner;
            push_n = 1'b0;
            if (m_owner >= 0) begin
                if (!(e_sw || e_sr)) nxt = -1;
                else if (!s_wait) begin
                    m_last = m_owner;
                    push_n = e_sr;
                    nxt = -1;
                end
            end else if (el[0] && el[1]) nxt = 1 - m_last;
            else if (el[0]) nxt = 0;
            else if (el[1]) nxt = 1;
            e_rv = '{1'b0, 1'b0};
            if (s_rdv) begin
                if (sz > 0) begin
                    t = tq.pop_front();
                    e_rv[t] = 1'b1;
                    e_rd[t] = s_rdata;
                end else m_orph = 1'b1;
            end
            if (push_n) tq.push_back(m_owner);
            m_owner = nxt;
        end
        @(negedge clk);
        chk("m0_readdatavalid", m0_bus.readdatavalid, e_rv[0]);
        chk("m1_readdatavalid", m1_bus.readdatavalid, e_rv[1]);
        chk("m0_readdata", m0_bus.readdata, e_rd[0]);
        chk("m1_readdata", m1_bus.readdata, e_rd[1]);
        chk("pending_count", pend, tq.size());
        chk("err_orphan", orph_o, m_orph);
        sn_rv[0] = m0_bus.readdatavalid;
        sn_rv[1] = m1_bus.readdatavalid;
        sn_rd[0] = m0_bus.readdata;
        sn_rd[1] = m1_bus.readdata;
        sn_pend = pend;
        sn_orph = orph_o;
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            rd[n] = 1'b0;
            wr[n] = 1'b0;
            addr[n] = '0;
            wdata[n] = '0;
            be[n] = 2'b11;
        end
        s_wait = 1'b0;
        s_rdv = 1'b0;
        s_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        clear_inputs();
        for (int i = 0; i < 40 && ctl_out > 0; i++) begin
            s_rdv = 1'b1;
            s_rdata = DW'($urandom);
            step();
        end
        s_rdv = 1'b0;
        step();
        chk("drain_pending", sn_pend, 0);
    endtask

    int ord[$];
    int exp_ord[4] = '{0, 1, 0, 1};
    int k, got;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        @(negedge clk);
        do_reset();
        chk("rst_pending", sn_pend, 0);
        chk("rst_orphan", sn_orph, 0);
        chk("rst_rv0", sn_rv[0], 0);
        chk("rst_rd1", sn_rd[1], 0);
        step();
        chk("rst_m0_wait", sn_wait[0], 1);
        chk("rst_m1_wait", sn_wait[1], 1);
        chk("rst_sdr_write", sn_sw, 0);
        chk("rst_sdr_read", sn_sr, 0);

        // Single write from m0.
        addr[0] = 25'h100;
        wdata[0] = 16'hBEEF;
        wr[0] = 1'b1;
        step();
        chk("wr_idle_m0_wait", sn_wait[0], 1);
        chk("wr_idle_sdr_write", sn_sw, 0);
        step();
        chk("wr_sdr_write", sn_sw, 1);
        chk("wr_sdr_addr", sn_addr, 25'h100);
        chk("wr_sdr_wdata", sn_wd, 16'hBEEF);
        chk("wr_m0_wait_low", sn_wait[0], 0);
        wr[0] = 1'b0;
        step();
        chk("wr_after_sdr_write", sn_sw, 0);
        chk("wr_after_m0_wait", sn_wait[0], 1);

        // Both reading continuously: strict alternation starting with m0.
        do_reset();
        rd[0] = 1'b1;
        rd[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            for (int n = 0; n < 2; n++) if (acc[n]) ord.push_back(n);
        end
        clear_inputs();
        step();
        chk("rr_accepts", ord.size(), 4);
        for (int i = 0; i < 4 && i < ord.size(); i++) chk($sformatf("rr_order%0d", i), ord[i], exp_ord[i]);
        chk("rr_pending", sn_pend, 4);
        drain();

        // Fill the tag FIFO from m1, then one return frees a slot.
        do_reset();
        rd[1] = 1'b1;
        for (int i = 0; i < 40 && sn_pend != 4'd8; i++) step();
        chk("full_pending", sn_pend, 8);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (acc[1]) got++;
        end
        chk("full_no_issue", got, 0);
        chk("full_pending_hold", sn_pend, 8);
        s_rdv = 1'b1;
        s_rdata = 16'h5A5A;
        step();
        s_rdv = 1'b0;
        chk("full_ret_rv1", sn_rv[1], 1);
        chk("full_ret_rd1", sn_rd[1], 16'h5A5A);
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step();
            if (acc[1]) got = 1;
        end
        chk("ninth_issued", got, 1);
        drain();

        // Interleaved reads m0,m1,m0 and in-order steering of returns.
        do_reset();
        rd[0] = 1'b1;
        rd[1] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            step();
            if (acc[0] || acc[1]) got++;
        end
        chk("ilv_issued", got, 3);
        clear_inputs();
        s_rdv = 1'b1;
        s_rdata = 16'h1111;
        step();
        chk("ilv_r1_rv0", sn_rv[0], 1);
        chk("ilv_r1_rd0", sn_rd[0], 16'h1111);
        chk("ilv_r1_rv1", sn_rv[1], 0);
        s_rdata = 16'h2222;
        step();
        chk("ilv_r2_rv1", sn_rv[1], 1);
        chk("ilv_r2_rd1", sn_rd[1], 16'h2222);
        s_rdata = 16'h3333;
        step();
        chk("ilv_r3_rv0", sn_rv[0], 1);
        chk("ilv_r3_rd0", sn_rd[0], 16'h3333);
        s_rdv = 1'b0;
        step();
        chk("ilv_quiet_rv0", sn_rv[0], 0);
        chk("ilv_pending", sn_pend, 0);

        // Controller stalls m0's write for 5 cycles; m1 waits behind it.
        do_reset();
        addr[0] = 25'hABCDE;
        wdata[0] = 16'h1234;
        addr[1] = 25'h00777;
        wdata[1] = 16'h9876;
        wr[0] = 1'b1;
        wr[1] = 1'b1;
        s_wait = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_sdr_write", sn_sw, 1);
            chk("stall_sdr_addr", sn_addr, 25'hABCDE);
            chk("stall_m0_wait", sn_wait[0], 1);
            chk("stall_m1_wait", sn_wait[1], 1);
        end
        s_wait = 1'b0;
        step();
        chk("stall_m0_acc", acc[0], 1);
        chk("stall_m1_still_wait", sn_wait[1], 1);
        wr[0] = 1'b0;
        step();
        step();
        chk("stall_m1_acc", acc[1], 1);
        chk("stall_m1_addr", sn_addr, 25'h00777);
        wr[1] = 1'b0;
        step();

        // Orphan return is dropped and sticky until reset; also after a mid-flight reset.
        do_reset();
        s_rdv = 1'b1;
        s_rdata = 16'hDEAD;
        step();
        s_rdv = 1'b0;
        chk("orph_rv0", sn_rv[0], 0);
        chk("orph_rv1", sn_rv[1], 0);
        chk("orph_set", sn_orph, 1);
        step();
        chk("orph_sticky", sn_orph, 1);
        do_reset();
        chk("orph_cleared", sn_orph, 0);
        rd[0] = 1'b1;
        step();
        step();
        chk("late_read_acc", acc[0], 1);
        do_reset();
        s_rdv = 1'b1;
        step();
        s_rdv = 1'b0;
        chk("late_ret_orph", sn_orph, 1);
        chk("late_ret_rv0", sn_rv[0], 0);

        // Random traffic.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (acc[n] || ((rd[n] || wr[n]) && $urandom_range(0, 63) == 0)) begin
                    rd[n] = 1'b0;
                    wr[n] = 1'b0;
                end
                if (!rd[n] && !wr[n] && $urandom_range(0, 2) == 0) begin
                    k = int'($urandom_range(0, 9));
                    wr[n] = (k < 4) || (k == 9);
                    rd[n] = (k >= 4);
                    addr[n] = AW'($urandom);
                    wdata[n] = DW'($urandom);
                    be[n] = 2'($urandom);
                end
            end
            s_wait = ($urandom_range(0, 3) == 0);
            s_rdv = (ctl_out > 0) && ($urandom_range(0, 3) == 0);
            s_rdata = DW'($urandom);
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
